// File: rtl/overture_pkg.sv
// Shared definitions for the Overture instruction encoder.
//  - class codes occupying the top two bits of every instruction byte
//  - request kinds accepted on the request port (including the two pseudo-ops)
//  - ALU operation and condition selector codes
//  - FSM state type for the encoder top
//  - pack_instr: joins a class code and a 6-bit payload into one byte
package overture_pkg;

  localparam logic [1:0] CLS_IMM  = 2'b00;
  localparam logic [1:0] CLS_CALC = 2'b01;
  localparam logic [1:0] CLS_COPY = 2'b10;
  localparam logic [1:0] CLS_COND = 2'b11;

  typedef enum logic [2:0] {
    KindImm  = 3'd0,
    KindCalc = 3'd1,
    KindCopy = 3'd2,
    KindCond = 3'd3,
    KindLdr  = 3'd4,
    KindJmp  = 3'd5
  } req_kind_e;

  // ALU operation codes carried in the CALC payload.
  localparam logic [2:0] ALU_OR   = 3'd0;
  localparam logic [2:0] ALU_NAND = 3'd1;
  localparam logic [2:0] ALU_NOR  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_ADD  = 3'd4;
  localparam logic [2:0] ALU_SUB  = 3'd5;

  // Condition selectors carried in the COND payload (tested against the result register).
  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_EQZ    = 3'd1;
  localparam logic [2:0] COND_LTZ    = 3'd2;
  localparam logic [2:0] COND_LEZ    = 3'd3;
  localparam logic [2:0] COND_ALWAYS = 3'd4;
  localparam logic [2:0] COND_NEZ    = 3'd5;
  localparam logic [2:0] COND_GEZ    = 3'd6;
  localparam logic [2:0] COND_GTZ    = 3'd7;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEmit1 = 2'd1,
    StEmit2 = 2'd2
  } enc_state_e;

  function automatic logic [7:0] pack_instr(input logic [1:0] cls, input logic [5:0] payload);
    return {cls, payload};
  endfunction

endpackage

// File: rtl/overture_instr_pack.sv
// Combinational request-to-bytes translator.
// Ports:
//  kind      in  3  request kind (0..5 legal, 6..7 illegal)
//  imm       in  8  immediate for IMM/LDR/JMP
//  src       in  3  COPY source
//  dst       in  3  COPY/LDR destination
//  op        in  3  CALC alu op / COND and JMP condition
//  byte0     out 8  first (or only) byte to emit
//  byte1     out 8  second byte, meaningful only when two_byte=1
//  two_byte  out 1  request expands to two bytes
//  err_kind  out 1  illegal kind (takes priority over err_imm)
//  err_imm   out 1  immediate out of range (only when CHECK_IMM=1)
module overture_instr_pack
  import overture_pkg::*;
#(
  parameter bit CHECK_IMM = 1'b1
) (
  input  logic [2:0] kind,
  input  logic [7:0] imm,
  input  logic [2:0] src,
  input  logic [2:0] dst,
  input  logic [2:0] op,
  output logic [7:0] byte0,
  output logic [7:0] byte1,
  output logic       two_byte,
  output logic       err_kind,
  output logic       err_imm
);

  logic imm_bad;

  // Immediate field is 6 bits wide; anything above 63 cannot be encoded.
  assign imm_bad = CHECK_IMM && (imm[7:6] != 2'b00);

  always_comb begin
    byte0    = 8'h00;
    byte1    = 8'h00;
    two_byte = 1'b0;
    err_kind = 1'b0;
    err_imm  = 1'b0;
    case (kind)
      KindImm: begin
        byte0   = pack_instr(CLS_IMM, imm[5:0]);
        err_imm = imm_bad;
      end
      KindCalc: byte0 = pack_instr(CLS_CALC, {3'b000, op});
      KindCopy: byte0 = pack_instr(CLS_COPY, {src, dst});
      KindCond: byte0 = pack_instr(CLS_COND, {3'b000, op});
      KindLdr: begin
        byte0    = pack_instr(CLS_IMM, imm[5:0]);
        byte1    = pack_instr(CLS_COPY, {3'b000, dst});
        // The IMM already lands in register 0, so a copy 0->0 is dropped.
        two_byte = (dst != 3'd0);
        err_imm  = imm_bad;
      end
      KindJmp: begin
        byte0    = pack_instr(CLS_IMM, imm[5:0]);
        byte1    = pack_instr(CLS_COND, {3'b000, op});
        two_byte = 1'b1;
        err_imm  = imm_bad;
      end
      default: err_kind = 1'b1;
    endcase
  end

endmodule

// File: rtl/overture_encoder_8bit.sv
// Overture instruction encoder: accepts structured requests and streams the encoded
// machine bytes over a valid/ready byte port, expanding LDR and JMP into two bytes.
// Ports:
//  clk, rst                 clock and asynchronous active-high reset
//  req_valid/req_ready      request handshake
//  req_kind/imm/src/dst/op  request fields, sampled only on the handshake
//  out_valid/out_ready      byte handshake
//  out_instr, out_last      encoded byte and last-byte-of-request flag
//  err_imm, err_kind        one-cycle pulses for dropped requests
//  emit_count               bytes handshaken since reset (wraps)
module overture_encoder_8bit
  import overture_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter bit          CHECK_IMM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_kind,
  input  logic [7:0]       req_imm,
  input  logic [2:0]       req_src,
  input  logic [2:0]       req_dst,
  input  logic [2:0]       req_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_instr,
  output logic             out_last,
  output logic             err_imm,
  output logic             err_kind,
  output logic [CNT_W-1:0] emit_count
);

  enc_state_e state_q, state_d;

  logic [7:0] pk_byte0, pk_byte1;
  logic       pk_two_byte, pk_err_kind, pk_err_imm;
  logic       pk_err;

  logic [7:0] second_q;
  logic       two_byte_q;

  logic req_fire;
  logic out_fire;

  overture_instr_pack #(
    .CHECK_IMM (CHECK_IMM)
  ) u_pack (
    .kind     (req_kind),
    .imm      (req_imm),
    .src      (req_src),
    .dst      (req_dst),
    .op       (req_op),
    .byte0    (pk_byte0),
    .byte1    (pk_byte1),
    .two_byte (pk_two_byte),
    .err_kind (pk_err_kind),
    .err_imm  (pk_err_imm)
  );

  assign pk_err   = pk_err_kind | pk_err_imm;
  assign req_fire = req_valid & req_ready;
  assign out_fire = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire && !pk_err) state_d = StEmit1;
      end
      StEmit1: begin
        if (out_ready) state_d = two_byte_q ? StEmit2 : StIdle;
      end
      StEmit2: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  req_ready = 1'b1;
      StEmit1: out_valid = 1'b1;
      StEmit2: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Output byte register and second-byte stash. Both only move on a handshake,
  // so the presented byte cannot change while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instr  <= 8'h00;
      out_last   <= 1'b0;
      second_q   <= 8'h00;
      two_byte_q <= 1'b0;
      err_imm    <= 1'b0;
      err_kind   <= 1'b0;
    end else begin
      err_imm  <= 1'b0;
      err_kind <= 1'b0;
      if (state_q == StIdle && req_fire) begin
        if (pk_err) begin
          err_kind <= pk_err_kind;
          err_imm  <= pk_err_imm & ~pk_err_kind;
        end else begin
          out_instr  <= pk_byte0;
          out_last   <= ~pk_two_byte;
          second_q   <= pk_byte1;
          two_byte_q <= pk_two_byte;
        end
      end else if (state_q == StEmit1 && out_ready && two_byte_q) begin
        out_instr <= second_q;
        out_last  <= 1'b1;
      end
    end
  end

  // Emitted-byte counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      emit_count <= '0;
    end else if (out_fire) begin
      emit_count <= emit_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_overture_encoder_8bit.sv
module tb_overture_encoder_8bit;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_kind;
  logic [7:0] req_imm;
  logic [2:0] req_src;
  logic [2:0] req_dst;
  logic [2:0] req_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic       out_last;
  logic       err_imm;
  logic       err_kind;
  logic [7:0] emit_count;

  int vectors;
  int miscompares;

  overture_encoder_8bit #(
    .CNT_W     (8),
    .CHECK_IMM (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_imm    (req_imm),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .req_op     (req_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_last   (out_last),
    .err_imm    (err_imm),
    .err_kind   (err_kind),
    .emit_count (emit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one cycle (caller is in IDLE), then scramble fields.
  task automatic send(input logic [2:0] kind, input logic [7:0] imm, input logic [2:0] src,
                      input logic [2:0] dst, input logic [2:0] op);
    req_kind  = kind;
    req_imm   = imm;
    req_src   = src;
    req_dst   = dst;
    req_op    = op;
    req_valid = 1'b1;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    req_kind  = 3'd2;
    req_imm   = 8'h3F;
    req_src   = 3'd7;
    req_dst   = 3'd7;
    req_op    = 3'd7;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b, input logic last);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_instr"}, {24'b0, out_instr}, {24'b0, b});
    chk({tag, "_last"}, {31'b0, out_last}, {31'b0, last});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    vectors     = 0;
    miscompares = 0;
    req_valid   = 1'b0;
    req_kind    = 3'd0;
    req_imm     = 8'h00;
    req_src     = 3'd0;
    req_dst     = 3'd0;
    req_op      = 3'd0;
    out_ready   = 1'b1;
    rst         = 1'b0;
    #2;
    do_reset();

    // Reset state.
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", {24'b0, out_instr}, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_err_imm", {31'b0, err_imm}, 32'd0);
    chk("rst_err_kind", {31'b0, err_kind}, 32'd0);
    chk("rst_count", {24'b0, emit_count}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    exp_cnt = 0;

    // IMM 5 -> 0x05, then one IDLE bubble.
    send(3'd0, 8'd5, 3'd0, 3'd0, 3'd0);
    expect_byte("imm5", 8'h05, 1'b1);
    chk("imm5_req_ready", {31'b0, req_ready}, 32'd0);
    chk("imm5_count_before", {24'b0, emit_count}, 32'd0);
    step();
    exp_cnt++;
    chk("imm5_count_after", {24'b0, emit_count}, exp_cnt);
    chk("imm5_bubble", {31'b0, out_valid}, 32'd0);

    // COPY src=1 dst=2 -> 0x8A.
    send(3'd2, 8'd0, 3'd1, 3'd2, 3'd0);
    expect_byte("copy", 8'h8A, 1'b1);
    step();
    exp_cnt++;

    // CALC op=4 -> 0x44.
    send(3'd1, 8'd0, 3'd0, 3'd0, 3'd4);
    expect_byte("calc", 8'h44, 1'b1);
    step();
    exp_cnt++;

    // LDR imm=20 dst=4 with a 3-cycle stall on the first byte.
    out_ready = 1'b0;
    send(3'd4, 8'd20, 3'd0, 3'd4, 3'd0);
    expect_byte("ldr_b0", 8'h14, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_byte("ldr_stall", 8'h14, 1'b0);
      chk("ldr_stall_req_ready", {31'b0, req_ready}, 32'd0);
      chk("ldr_stall_count", {24'b0, emit_count}, exp_cnt);
    end
    out_ready = 1'b1;
    step();
    exp_cnt++;
    expect_byte("ldr_b1", 8'h84, 1'b1);
    chk("ldr_b1_req_ready", {31'b0, req_ready}, 32'd0);
    step();
    exp_cnt++;
    chk("ldr_count", {24'b0, emit_count}, exp_cnt);

    // JMP imm=10 op=1 -> 0x0A, 0xC1.
    send(3'd5, 8'd10, 3'd0, 3'd0, 3'd1);
    expect_byte("jmp_b0", 8'h0A, 1'b0);
    step();
    exp_cnt++;
    expect_byte("jmp_b1", 8'hC1, 1'b1);
    step();
    exp_cnt++;

    // LDR imm=7 dst=0 -> single byte 0x07.
    send(3'd4, 8'd7, 3'd0, 3'd0, 3'd0);
    expect_byte("ldr_d0", 8'h07, 1'b1);
    step();
    exp_cnt++;
    chk("ldr_d0_count", {24'b0, emit_count}, exp_cnt);
    chk("ldr_d0_idle", {31'b0, out_valid}, 32'd0);

    // Dropped requests: imm out of range, kinds 6 and 7.
    send(3'd0, 8'd64, 3'd0, 3'd0, 3'd0);
    chk("imm64_err_imm", {31'b0, err_imm}, 32'd1);
    chk("imm64_err_kind", {31'b0, err_kind}, 32'd0);
    chk("imm64_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("imm64_err_pulse", {31'b0, err_imm}, 32'd0);
    chk("imm64_valid2", {31'b0, out_valid}, 32'd0);
    chk("imm64_count", {24'b0, emit_count}, exp_cnt);

    // Kind 6 with a bad immediate too: err_kind wins.
    send(3'd6, 8'd200, 3'd0, 3'd0, 3'd0);
    chk("k6_err_kind", {31'b0, err_kind}, 32'd1);
    chk("k6_err_imm", {31'b0, err_imm}, 32'd0);
    chk("k6_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("k6_err_pulse", {31'b0, err_kind}, 32'd0);
    chk("k6_count", {24'b0, emit_count}, exp_cnt);

    send(3'd7, 8'd1, 3'd0, 3'd0, 3'd0);
    chk("k7_err_kind", {31'b0, err_kind}, 32'd1);
    chk("k7_err_imm", {31'b0, err_imm}, 32'd0);
    chk("k7_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("k7_err_pulse", {31'b0, err_kind}, 32'd0);
    chk("k7_valid2", {31'b0, out_valid}, 32'd0);
    chk("k7_count", {24'b0, emit_count}, exp_cnt);

    // Counter wrap: 256 IMM bytes from reset.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      send(3'd0, {2'b00, iv[5:0]}, 3'd0, 3'd0, 3'd0);
      expect_byte("wrap_byte", {2'b00, iv[5:0]}, 1'b1);
      step();
      if (i == 254) chk("wrap_count_255", {24'b0, emit_count}, 32'd255);
    end
    chk("wrap_count_0", {24'b0, emit_count}, 32'd0);

    // Reset during first byte of JMP: no second byte ever.
    send(3'd5, 8'd10, 3'd0, 3'd0, 3'd1);
    expect_byte("rstjmp_b0", 8'h0A, 1'b0);
    chk("rstjmp_count_pre", {24'b0, emit_count}, 32'd0);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstjmp_valid", {31'b0, out_valid}, 32'd0);
    chk("rstjmp_count", {24'b0, emit_count}, 32'd0);
    chk("rstjmp_instr", {24'b0, out_instr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rstjmp_after_valid", {31'b0, out_valid}, 32'd0);
      chk("rstjmp_after_instr", {24'b0, out_instr}, 32'd0);
    end
    chk("rstjmp_after_count", {24'b0, emit_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
